// File: rtl/vram_banked.sv
// Banked VDP video RAM: a 16-bit byte-maskable port, a BANKS x 16 wide read port,
// and a clear engine that fills every word with FILL_VALUE.
module vram_banked #(
  parameter int unsigned AW             = 15,
  parameter int unsigned BANKS          = 2,
  parameter logic [15:0] FILL_VALUE     = 16'h0,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic                  clear_done,
  input  logic                  vram_req,
  output logic                  vram_ack,
  input  logic                  vram_we,
  input  logic                  vram_u_n,
  input  logic                  vram_l_n,
  input  logic [AW:1]           vram_a,
  input  logic [15:0]           vram_d,
  output logic [15:0]           vram_q,
  input  logic                  vramw_req,
  output logic                  vramw_ack,
  input  logic [AW:1]           vramw_a,
  output logic [16*BANKS-1:0]   vramw_q
);

  localparam int unsigned BL   = $clog2(BANKS);
  localparam int unsigned RW   = AW - BL;
  localparam int unsigned ROWS = 1 << RW;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
  localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  logic [15:0]         mem [BANKS][ROWS];
  logic [15:0]         rdat_a;
  logic [16*BANKS-1:0] rdat_w;

  state_t              state_q, state_d;
  logic [RW-1:0]       row_q, row_d;
  logic                done_q, done_d;
  logic                ack_a_q, ack_a_d;
  logic                busy_a_q, busy_a_d;
  logic                rd_a_q, rd_a_d;
  logic [15:0]         vram_q_q, vram_q_d;
  logic                ack_w_q, ack_w_d;
  logic                busy_w_q, busy_w_d;
  logic [16*BANKS-1:0] vramw_q_q, vramw_q_d;

  logic [BL-1:0]       a_bank;
  logic [RW-1:0]       a_row;
  logic [RW-1:0]       w_row;
  logic                a_go;
  logic                w_go;
  logic                unused_wide_bits;

  assign a_bank           = vram_a[BL:1];
  assign a_row            = vram_a[AW:BL+1];
  assign w_row            = vramw_a[AW:BL+1];
  assign unused_wide_bits = ^vramw_a[BL:1];

  // Capture only while idle; the busy flag blocks re-capture until the ack toggles.
  assign a_go = (vram_req != ack_a_q) && !busy_a_q && (state_q == ST_IDLE);
  assign w_go = (vramw_req != ack_w_q) && !busy_w_q && (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    done_d    = 1'b0;
    ack_a_d   = ack_a_q;
    busy_a_d  = a_go;
    rd_a_d    = a_go ? !vram_we : rd_a_q;
    vram_q_d  = vram_q_q;
    ack_w_d   = ack_w_q;
    busy_w_d  = w_go;
    vramw_q_d = vramw_q_q;

    if (busy_a_q) begin
      ack_a_d = ~ack_a_q;
      if (rd_a_q) vram_q_d = rdat_a;
    end
    if (busy_w_q) begin
      ack_w_d   = ~ack_w_q;
      vramw_q_d = rdat_w;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          row_d   = '0;
        end
      end
      ST_CLEAR: begin
        row_d = row_q + 1'b1;
        if (row_q == RW'(ROWS - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RST_STATE;
      row_q     <= '0;
      done_q    <= 1'b0;
      ack_a_q   <= 1'b0;
      busy_a_q  <= 1'b0;
      rd_a_q    <= 1'b0;
      vram_q_q  <= '0;
      ack_w_q   <= 1'b0;
      busy_w_q  <= 1'b0;
      vramw_q_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      done_q    <= done_d;
      ack_a_q   <= ack_a_d;
      busy_a_q  <= busy_a_d;
      rd_a_q    <= rd_a_d;
      vram_q_q  <= vram_q_d;
      ack_w_q   <= ack_w_d;
      busy_w_q  <= busy_w_d;
      vramw_q_q <= vramw_q_d;
    end
  end

  // Reads and writes share one block so a same-edge write/read returns the old word.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      for (int unsigned k = 0; k < BANKS; k++) mem[BL'(k)][row_q] <= FILL_VALUE;
    end
    if (a_go) begin
      if (vram_we) begin
        if (!vram_u_n) mem[a_bank][a_row][15:8] <= vram_d[15:8];
        if (!vram_l_n) mem[a_bank][a_row][7:0]  <= vram_d[7:0];
      end
      rdat_a <= mem[a_bank][a_row];
    end
    if (w_go) begin
      for (int unsigned k = 0; k < BANKS; k++) rdat_w[16*k +: 16] <= mem[BL'(k)][w_row];
    end
  end

  assign clear_busy = (state_q == ST_CLEAR);
  assign clear_done = done_q;
  assign vram_ack   = ack_a_q;
  assign vram_q     = vram_q_q;
  assign vramw_ack  = ack_w_q;
  assign vramw_q    = vramw_q_q;

endmodule

// File: tb/tb_vram_banked.sv
// Scoreboard bench for vram_banked: flat word-array reference model, randomized traffic,
// clear timing and reset-during-clear checks.
module tb_vram_banked;
  localparam int          AW    = 13;
  localparam int          BANKS = 4;
  localparam int          ROWS  = (1 << AW) / BANKS;
  localparam logic [15:0] FILL  = 16'hA5C3;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               clear_req = 1'b0;
  logic               clear_busy, clear_done;
  logic               vram_req = 1'b0, vram_ack;
  logic               vram_we = 1'b0, vram_u_n = 1'b1, vram_l_n = 1'b1;
  logic [AW:1]        vram_a = '0;
  logic [15:0]        vram_d = '0, vram_q;
  logic               vramw_req = 1'b0, vramw_ack;
  logic [AW:1]        vramw_a = '0;
  logic [16*BANKS-1:0] vramw_q;

  vram_banked #(
    .AW(AW), .BANKS(BANKS), .FILL_VALUE(FILL), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
    .vram_req(vram_req), .vram_ack(vram_ack), .vram_we(vram_we),
    .vram_u_n(vram_u_n), .vram_l_n(vram_l_n), .vram_a(vram_a),
    .vram_d(vram_d), .vram_q(vram_q),
    .vramw_req(vramw_req), .vramw_ack(vramw_ack), .vramw_a(vramw_a), .vramw_q(vramw_q)
  );

  always #5 clk = ~clk;

  logic [15:0]         model [1 << AW];
  logic [15:0]         exp_a [$];
  logic [16*BANKS-1:0] exp_w [$];
  logic [15:0]         last_rd = '0;
  int                  total = 0;
  int                  bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic fill_model();
    foreach (model[i]) model[i] = FILL;
  endtask

  task automatic issue_a(input bit we, input bit u_n, input bit l_n, input int addr,
                         input logic [15:0] d);
    vram_we = we; vram_u_n = u_n; vram_l_n = l_n; vram_a = AW'(addr); vram_d = d;
    if (we) begin
      if (!u_n) model[addr][15:8] = d[15:8];
      if (!l_n) model[addr][7:0]  = d[7:0];
    end else begin
      last_rd = model[addr];
    end
    exp_a.push_back(last_rd);
    vram_req = ~vram_req;
  endtask

  task automatic issue_w(input int addr);
    logic [16*BANKS-1:0] e;
    int base;
    base = addr - (addr % BANKS);
    e = '0;
    for (int k = 0; k < BANKS; k++) e[16*k +: 16] = model[base + k];
    exp_w.push_back(e);
    vramw_a = AW'(addr);
    vramw_req = ~vramw_req;
  endtask

  task automatic wait_idle(input bit lat);
    int n = 0;
    while ((vram_ack !== vram_req || vramw_ack !== vramw_req) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (lat) chk("ack_latency", n, 2);
    else     chk("ack_arrived", (vram_ack === vram_req) && (vramw_ack === vramw_req), 1);
  endtask

  task automatic wait_clear(output int cnt, output int dn);
    cnt = 0; dn = 0;
    while (clear_busy && cnt < ROWS + 50) begin
      cnt++;
      @(posedge clk); #1;
      if (clear_done) dn++;
    end
    @(posedge clk); #1;
    if (clear_done) dn++;
  endtask

  logic pa = 1'b0, pw = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      pa = vram_ack;
      pw = vramw_ack;
    end else begin
      if (vram_ack !== pa) begin
        if (exp_a.size() == 0) chk("a_spurious_ack", 0, 1);
        else chk("a_q", vram_q, exp_a.pop_front());
        pa = vram_ack;
      end
      if (vramw_ack !== pw) begin
        if (exp_w.size() == 0) chk("w_spurious_ack", 0, 1);
        else chk("w_q", vramw_q, exp_w.pop_front());
        pw = vramw_ack;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, dn, a;
    logic we, u, l, wide;
    fill_model();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {vram_ack, vramw_ack}, 2'b00);
    chk("rst_q", vram_q, 16'h0);
    chk("rst_wq", vramw_q, '0);
    chk("rst_done", clear_done, 1'b0);
    chk("rst_busy", clear_busy, 1'b1);

    // Clear after reset exit
    reset_n = 1'b1;
    wait_clear(cnt, dn);
    chk("reset_clear_cycles", cnt, ROWS);
    chk("reset_clear_done_pulses", dn, 1);
    issue_a(0, 0, 0, 'h1234, '0);
    wait_idle(1);
    chk("post_clear_read", vram_q, FILL);

    // Upper-byte-only write
    issue_a(1, 0, 1, 'h0101, 16'hBEEF);
    wait_idle(1);
    chk("write_keeps_q", vram_q, FILL);
    issue_a(0, 0, 0, 'h0101, '0);
    wait_idle(1);
    chk("byte_upper", vram_q, {8'hBE, FILL[7:0]});
    issue_a(1, 1, 0, 'h0101, 16'h1200);
    wait_idle(1);
    issue_a(1, 1, 1, 'h0101, 16'h7777);
    wait_idle(1);
    issue_a(0, 0, 0, 'h0101, '0);
    wait_idle(1);
    chk("byte_lower_and_none", vram_q, 16'hBE00);

    // Wide row fetch
    issue_a(1, 0, 0, 'h40, 16'h1111); wait_idle(1);
    issue_a(1, 0, 0, 'h41, 16'h2222); wait_idle(1);
    issue_a(1, 0, 0, 'h42, 16'h3333); wait_idle(1);
    issue_a(1, 0, 0, 'h43, 16'h4444); wait_idle(1);
    issue_w('h42);
    wait_idle(1);
    chk("wide_row", vramw_q, 64'h4444_3333_2222_1111);

    // Same-cycle write and wide read: wide sees old data
    issue_a(1, 0, 0, 'h10, 16'h5555); wait_idle(1);
    issue_w('h10);
    issue_a(1, 0, 0, 'h10, 16'hAAAA);
    wait_idle(1);
    chk("collision_old", vramw_q[15:0], 16'h5555);
    issue_w('h10);
    wait_idle(1);
    chk("collision_new", vramw_q[15:0], 16'hAAAA);

    for (int i = 0; i < 200; i++) begin
      a    = $urandom_range(0, 255);
      we   = 1'($urandom_range(0, 1));
      u    = 1'($urandom_range(0, 1));
      l    = 1'($urandom_range(0, 1));
      wide = 1'($urandom_range(0, 1));
      if (wide) issue_w($urandom_range(0, 255));
      issue_a(we, u, l, a, 16'($urandom));
      wait_idle(1);
    end

    // Request captured on the clear_req edge completes; one issued during clear waits
    issue_a(0, 0, 0, 'h0101, '0);
    fill_model();
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    @(posedge clk); #1;
    chk("capture_with_clear", vram_ack, vram_req);
    chk("busy_after_req", clear_busy, 1'b1);
    issue_a(0, 0, 0, 'h0101, '0);
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    wait_clear(cnt, dn);
    // two busy cycles elapsed before counting began
    chk("clear_cycles_left", cnt, ROWS - 2);
    chk("clear_done_pulses", dn, 1);
    chk("ack_withheld", vram_ack != vram_req, 1'b1);
    wait_idle(0);
    chk("read_after_clear", vram_q, FILL);

    // Reset in the middle of a clear
    issue_a(1, 0, 0, 'h1FFF, 16'h1357); wait_idle(1);
    issue_a(0, 0, 0, 'h1FFF, '0);
    issue_w('h1FFD);
    wait_idle(1);
    if (vram_ack == 1'b0) begin
      issue_a(0, 0, 0, 'h1FFF, '0);
      wait_idle(1);
    end
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_ack", {vram_ack, vramw_ack}, 2'b00);
    chk("midrst_q", vram_q, 16'h0);
    chk("midrst_wq", vramw_q, '0);
    vram_req = 1'b0; vramw_req = 1'b0; last_rd = '0;
    fill_model();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_clear(cnt, dn);
    chk("restart_clear_cycles", cnt, ROWS);
    chk("restart_done_pulses", dn, 1);
    issue_w('h1FFC);
    issue_a(0, 0, 0, 'h1FFF, '0);
    wait_idle(1);
    chk("high_row_cleared", vram_q, FILL);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_a.size() + exp_w.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
